reg_skid_buf: RTL and testbench

- Two-entry valid/ready pipeline register (skid buffer) between core pipeline stages.
- Feeds the enabled stage registers downstream: its o_valid/i_ready handshake generates their load enables, and its o_data is their data input.
- Breaks the combinational ready path: o_ready is a flop, and full throughput of one beat per cycle is kept.

---
 rtl/reg_skid_buf.sv | 153 +++++++++++++++
 tb/tb_reg_skid_buf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_skid_buf.sv
// reg_skid_buf: two-entry valid/ready skid buffer between pipeline stages.
// The upstream ready (o_ready) is a flop, so the ready path is cut without
// losing throughput: one beat per cycle while downstream keeps i_ready high.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_flush  - synchronous active-high flush (only with REG_SKID_FLUSH_EN)
//   i_valid  - upstream beat valid
//   o_ready  - buffer accepts a beat this cycle (registered)
//   i_data   - upstream payload
//   o_valid  - downstream beat valid (registered)
//   i_ready  - downstream takes the beat this cycle
//   o_data   - downstream payload, driven straight from the main register
//
// Optional feature: define REG_SKID_FLUSH_EN to add i_flush. A flush empties
// the buffer (both held beats dropped, any incoming beat discarded) while the
// data registers keep their contents.
module reg_skid_buf #(
    parameter int unsigned               DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]     RSTN_VALUE = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
`ifdef REG_SKID_FLUSH_EN
    input  logic                  i_flush,
`endif
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data
);

    // Occupancy states: EMPTY (no beat), BUSY (main holds one), FULL (main+skid)
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  ready_q;
    logic                  valid_q;
    logic                  ready_nxt;
    logic                  valid_nxt;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;

    logic                  in_fire;
    logic                  out_fire;
    logic                  flush_c;
    logic                  load_main;
    logic                  load_skid;
    logic                  main_from_skid;

    // Flush source; tied off when the feature is not built
`ifdef REG_SKID_FLUSH_EN
    assign flush_c = i_flush;
`else
    assign flush_c = 1'b0;
`endif

    // Handshake events, all from registered outputs
    assign in_fire  = i_valid & ready_q;
    assign out_fire = valid_q & i_ready;

    // State register plus the registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= ready_nxt;
            valid_q <= valid_nxt;
        end
    end

    // Next-state and data-load decode
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;

        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    // Pass-through: replace the departing beat
                    load_main = 1'b1;
                end else if (in_fire) begin
                    // Downstream stalled: park the new beat in skid
                    load_skid = 1'b1;
                    state_nxt = ST_FULL;
                end else if (out_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // o_ready is low here, so only a drain can happen
                if (out_fire) begin
                    main_from_skid = 1'b1;
                    state_nxt      = ST_BUSY;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase

        // Flush overrides every handshake transition; data regs untouched
        if (flush_c) begin
            state_nxt      = ST_EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end

        // Outputs are a pure function of the next state, then registered
        ready_nxt = (state_nxt != ST_FULL);
        valid_nxt = (state_nxt != ST_EMPTY);
    end

    // Data registers load only on the decoded events
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q <= RSTN_VALUE;
            skid_q <= RSTN_VALUE;
        end else begin
            if (load_main) begin
                main_q <= i_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= i_data;
            end
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_data  = main_q;

endmodule

// File: tb/tb_reg_skid_buf.sv
// Self-checking bench for reg_skid_buf: directed scenarios plus a randomized
// stream, with a queue-based scoreboard checked by an independent monitor.
module tb_reg_skid_buf;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
`ifdef REG_SKID_FLUSH_EN
    logic          flush;
`endif

    reg_skid_buf #(.DATA_WIDTH(DW), .RSTN_VALUE('0)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
`ifdef REG_SKID_FLUSH_EN
        .i_flush (flush),
`endif
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rx_count = 0;

    // Reference model: beats accepted upstream and not yet delivered, in order
    logic [DW-1:0] exp_q[$];
    logic          armed;
    logic          stall_prev;
    logic [DW-1:0] prev_data;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready is only allowed once a clock edge has passed outside reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        stall_prev = 1'b0;
    end

    // Monitor: sampled mid-cycle, inputs and outputs are both settled
    always @(negedge clk) begin
        logic do_flush;
        logic [DW-1:0] exp_d;
        do_flush = 1'b0;
`ifdef REG_SKID_FLUSH_EN
        do_flush = flush;
`endif
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            chk("o_valid", DW'(o_valid), DW'(exp_q.size() > 0));
            chk("o_ready", DW'(o_ready), DW'(armed && (exp_q.size() < 2)));
            if (stall_prev) begin
                chk("stall_valid", DW'(o_valid), DW'(1'b1));
                chk("stall_data", o_data, prev_data);
            end
            stall_prev = o_valid && !i_ready && !do_flush;
            prev_data  = o_data;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none at %0t", o_data, $time);
                end else begin
                    exp_d = exp_q.pop_front();
                    chk("o_data", o_data, exp_d);
                    rx_count++;
                end
            end
            if (do_flush) exp_q.delete();
            else if (i_valid && o_ready) exp_q.push_back(i_data);
        end
    end

    // One stimulus cycle; acc reports whether the beat is taken at this edge
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, output logic acc);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        acc     = v && o_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        logic a;
        for (int k = 0; k < n; k++) step(1'b0, '0, r, a);
    endtask

    initial begin
        logic acc;
        int   guard;
        int   beat;
        int   sent;
        int   rx_start;

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b0;
`ifdef REG_SKID_FLUSH_EN
        flush   = 1'b0;
`endif
        stall_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", DW'(o_valid), DW'(1'b0));
        chk("rst_ready", DW'(o_ready), DW'(1'b0));
        chk("rst_data", o_data, '0);
        rst_n = 1'b1;
        idle(1, 1'b0);
        chk("ready_first_edge", DW'(o_ready), DW'(1'b1));

        // Streaming at full rate
        step(1'b1, 32'h11, 1'b1, acc);
        step(1'b1, 32'h22, 1'b1, acc);
        chk("stream_o_data", o_data, 32'h22);
        step(1'b1, 32'h33, 1'b1, acc);
        idle(3, 1'b1);

        // Backpressure: fill, hold off a third beat, then drain in order
        step(1'b1, 32'hA0, 1'b0, acc);
        step(1'b1, 32'hA1, 1'b0, acc);
        chk("bp_full_ready", DW'(o_ready), DW'(1'b0));
        step(1'b1, 32'hA2, 1'b0, acc);
        chk("bp_a2_held", DW'(acc), DW'(1'b0));
        step(1'b1, 32'hA2, 1'b0, acc);
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 10) begin
            step(1'b1, 32'hA2, 1'b1, acc);
            guard++;
        end
        chk("bp_a2_accept_timeout", DW'(acc), DW'(1'b1));
        idle(4, 1'b1);

        // Stall stability in BUSY
        step(1'b1, 32'hDEADBEEF, 1'b0, acc);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, '0, 1'b0, acc);
            chk("stall_hold_data", o_data, 32'hDEADBEEF);
            chk("stall_hold_valid", DW'(o_valid), DW'(1'b1));
        end
        idle(2, 1'b1);

        // Asynchronous reset while FULL
        step(1'b1, 32'h5A, 1'b0, acc);
        step(1'b1, 32'h5B, 1'b0, acc);
        i_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", DW'(o_valid), DW'(1'b0));
        chk("midrst_ready", DW'(o_ready), DW'(1'b0));
        chk("midrst_data", o_data, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", DW'(o_ready), DW'(1'b1));
        idle(2, 1'b1);

`ifdef REG_SKID_FLUSH_EN
        // Flush from FULL with a coincident incoming beat
        step(1'b1, 32'h5, 1'b0, acc);
        step(1'b1, 32'h6, 1'b0, acc);
        flush = 1'b1;
        step(1'b1, 32'h7, 1'b0, acc);
        flush = 1'b0;
        chk("flush_valid", DW'(o_valid), DW'(1'b0));
        chk("flush_ready", DW'(o_ready), DW'(1'b1));
        idle(4, 1'b1);
`endif

        // Random traffic with incrementing payloads
        rx_start = rx_count;
        beat  = 0;
        sent  = 0;
        guard = 0;
        while (sent < 1000 && guard < 20000) begin
            step(($urandom_range(0, 3) != 0), DW'(beat), ($urandom_range(0, 3) != 0), acc);
            if (acc) begin
                beat++;
                sent++;
            end
            guard++;
        end
        chk("rand_sent", DW'(sent), DW'(1000));
        idle(5, 1'b1);
        chk("rand_drained", DW'(exp_q.size()), '0);
        chk("rand_rx_count", DW'(rx_count - rx_start), DW'(1000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
